// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and load-type codes for the writeback stage
package wb_pkg;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_MEM
    } wb_state_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LD  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;
    localparam logic [2:0] LOAD_LWU = 3'b110;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - combinational byte/half/word lane select with sign/zero extension
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] addr_lo,
    output logic [XLEN-1:0]  result
);

    logic [OFF_W-1:0] half_off;
    logic [OFF_W-1:0] word_off;
    logic [XLEN-1:0]  b_lane;
    logic [XLEN-1:0]  h_lane;
    logic [XLEN-1:0]  w_lane;

    // Only the offset bits above the access size pick the lane; misalignment is ignored.
    assign half_off = addr_lo & ~OFF_W'(1);
    assign word_off = addr_lo & ~OFF_W'(3);
    assign b_lane   = data >> {addr_lo, 3'b000};
    assign h_lane   = data >> {half_off, 3'b000};
    assign w_lane   = data >> {word_off, 3'b000};

    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int n, input logic sgn);
        logic [XLEN-1:0]        t;
        logic signed [XLEN-1:0] s;
        t = v << (XLEN - n);
        s = $signed(t);
        s = s >>> (XLEN - n);
        t = t >> (XLEN - n);
        if (sgn) begin
            return $unsigned(s);
        end
        return t;
    endfunction

    always_comb begin
        result = data;
        case (funct3)
            LOAD_LB:  result = ext(b_lane, 8, 1'b1);
            LOAD_LH:  result = ext(h_lane, 16, 1'b1);
            LOAD_LW:  result = ext(w_lane, 32, 1'b1);
            LOAD_LBU: result = ext(b_lane, 8, 1'b0);
            LOAD_LHU: result = ext(h_lane, 16, 1'b0);
            LOAD_LWU: result = ext(w_lane, 32, 1'b0);
            LOAD_LD:  result = data;
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// rtl/wb_stage_pipelined.sv - writeback stage: source select, load wait FSM, register-file write and bypass
module wb_stage_pipelined
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 4,
    parameter int LOAD_IDX = 1,
    parameter int TIMEOUT  = 64,
    localparam int OFF_W   = $clog2(XLEN / 8),
    localparam int SEL_W   = $clog2(NUM_SRC),
    localparam int CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_in_valid,
    output logic                    io_in_ready,
    input  logic [SEL_W-1:0]        io_in_sel,
    input  logic [NUM_SRC*XLEN-1:0] io_in_src,
    input  logic [4:0]              io_in_rd,
    input  logic                    io_in_regwrite,
    input  logic [2:0]              io_in_funct3,
    input  logic [OFF_W-1:0]        io_in_addr_lo,
    input  logic                    io_mem_rsp_valid,
    input  logic [XLEN-1:0]         io_mem_rsp_data,
    output logic                    io_rf_wen,
    output logic [4:0]              io_rf_waddr,
    output logic [XLEN-1:0]         io_rf_wdata,
    output logic                    io_fwd_valid,
    output logic [4:0]              io_fwd_rd,
    output logic [XLEN-1:0]         io_fwd_data,
    output logic                    io_busy,
    output logic                    io_err_timeout,
    output logic                    io_err_unexp_rsp
);

    wb_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       lat_rd;
    logic             lat_regwrite;
    logic [2:0]       lat_funct3;
    logic [OFF_W-1:0] lat_addr_lo;

    logic [XLEN-1:0]  src_mux;
    logic [XLEN-1:0]  load_data;
    logic             load_accept;
    logic             wr_fire;
    logic [4:0]       wr_rd;
    logic             wr_regwrite;
    logic [XLEN-1:0]  wr_data;
    logic             timeout_fire;

    // Selects that fall outside the populated sources resolve to source 0.
    always_comb begin
        src_mux = io_in_src[XLEN-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (io_in_sel == SEL_W'(k)) begin
                src_mux = io_in_src[k*XLEN +: XLEN];
            end
        end
    end

    wb_load_align #(.XLEN(XLEN)) u_align (
        .data    (io_mem_rsp_data),
        .funct3  (lat_funct3),
        .addr_lo (lat_addr_lo),
        .result  (load_data)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        io_in_ready  = 1'b0;
        load_accept  = 1'b0;
        wr_fire      = 1'b0;
        wr_rd        = io_in_rd;
        wr_regwrite  = io_in_regwrite;
        wr_data      = src_mux;
        timeout_fire = 1'b0;
        case (state)
            WB_IDLE: begin
                io_in_ready = reset;
                if (io_in_valid && io_in_ready) begin
                    if (io_in_sel == SEL_W'(LOAD_IDX)) begin
                        load_accept = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = WB_WAIT_MEM;
                    end else begin
                        wr_fire = 1'b1;
                    end
                end
            end
            WB_WAIT_MEM: begin
                cnt_nxt = cnt + CNT_W'(1);
                // A response on the final allowed cycle still completes the load.
                if (io_mem_rsp_valid) begin
                    wr_fire     = 1'b1;
                    wr_rd       = lat_rd;
                    wr_regwrite = lat_regwrite;
                    wr_data     = load_data;
                    state_nxt   = WB_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_fire = 1'b1;
                    state_nxt    = WB_IDLE;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= WB_IDLE;
            cnt              <= '0;
            lat_rd           <= '0;
            lat_regwrite     <= 1'b0;
            lat_funct3       <= '0;
            lat_addr_lo      <= '0;
            io_rf_wen        <= 1'b0;
            io_rf_waddr      <= '0;
            io_rf_wdata      <= '0;
            io_err_timeout   <= 1'b0;
            io_err_unexp_rsp <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            io_rf_wen      <= 1'b0;
            io_err_timeout <= timeout_fire;
            if (load_accept) begin
                lat_rd       <= io_in_rd;
                lat_regwrite <= io_in_regwrite;
                lat_funct3   <= io_in_funct3;
                lat_addr_lo  <= io_in_addr_lo;
            end
            if (wr_fire) begin
                io_rf_wen   <= wr_regwrite && (wr_rd != 5'd0);
                io_rf_waddr <= wr_rd;
                io_rf_wdata <= wr_data;
            end
            if (state == WB_IDLE && io_mem_rsp_valid) begin
                io_err_unexp_rsp <= 1'b1;
            end
        end
    end

    assign io_busy      = (state == WB_WAIT_MEM);
    assign io_fwd_valid = io_rf_wen;
    assign io_fwd_rd    = io_rf_waddr;
    assign io_fwd_data  = io_rf_wdata;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// tb/tb_wb_stage_pipelined.sv - directed scoreboard bench for wb_stage_pipelined
module tb_wb_stage_pipelined;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 4;
    localparam int TIMEOUT = 4;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    io_in_valid;
    logic                    io_in_ready;
    logic [1:0]              io_in_sel;
    logic [NUM_SRC*XLEN-1:0] io_in_src;
    logic [4:0]              io_in_rd;
    logic                    io_in_regwrite;
    logic [2:0]              io_in_funct3;
    logic [1:0]              io_in_addr_lo;
    logic                    io_mem_rsp_valid;
    logic [XLEN-1:0]         io_mem_rsp_data;
    logic                    io_rf_wen;
    logic [4:0]              io_rf_waddr;
    logic [XLEN-1:0]         io_rf_wdata;
    logic                    io_fwd_valid;
    logic [4:0]              io_fwd_rd;
    logic [XLEN-1:0]         io_fwd_data;
    logic                    io_busy;
    logic                    io_err_timeout;
    logic                    io_err_unexp_rsp;

    logic [36:0] exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int wen_seen = 0;
    int to_seen  = 0;

    always #5 clock = ~clock;

    wb_stage_pipelined #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .LOAD_IDX(1), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_ready      (io_in_ready),
        .io_in_sel        (io_in_sel),
        .io_in_src        (io_in_src),
        .io_in_rd         (io_in_rd),
        .io_in_regwrite   (io_in_regwrite),
        .io_in_funct3     (io_in_funct3),
        .io_in_addr_lo    (io_in_addr_lo),
        .io_mem_rsp_valid (io_mem_rsp_valid),
        .io_mem_rsp_data  (io_mem_rsp_data),
        .io_rf_wen        (io_rf_wen),
        .io_rf_waddr      (io_rf_waddr),
        .io_rf_wdata      (io_rf_wdata),
        .io_fwd_valid     (io_fwd_valid),
        .io_fwd_rd        (io_fwd_rd),
        .io_fwd_data      (io_fwd_data),
        .io_busy          (io_busy),
        .io_err_timeout   (io_err_timeout),
        .io_err_unexp_rsp (io_err_unexp_rsp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample; every write pulse is matched against the scoreboard.
    task automatic tick();
        logic [36:0] e;
        @(posedge clock);
        #1;
        if (io_rf_wen === 1'b1) begin
            wen_seen++;
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rf_waddr", 64'(io_rf_waddr), 64'(e[36:32]));
                check("rf_wdata", 64'(io_rf_wdata), 64'(e[31:0]));
                check("fwd_valid", 64'(io_fwd_valid), 64'd1);
                check("fwd_rd", 64'(io_fwd_rd), 64'(e[36:32]));
                check("fwd_data", 64'(io_fwd_data), 64'(e[31:0]));
            end
        end
        if (io_err_timeout === 1'b1) to_seen++;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic regw,
                         input logic [2:0] f3, input logic [1:0] addr);
        io_in_sel      = sel;
        io_in_rd       = rd;
        io_in_regwrite = regw;
        io_in_funct3   = f3;
        io_in_addr_lo  = addr;
        io_in_valid    = 1'b1;
        check("ready_at_issue", 64'(io_in_ready), 64'd1);
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [1:0] addr, input logic [31:0] d,
                           input logic [4:0] rd, input int n_wait, input logic [31:0] exp);
        exp_q.push_back({rd, exp});
        issue(2'd1, rd, 1'b1, f3, addr);
        for (int i = 0; i < n_wait; i++) begin
            check("busy_wait", 64'(io_busy), 64'd1);
            check("ready_wait", 64'(io_in_ready), 64'd0);
            if (i == n_wait - 1) begin
                io_mem_rsp_valid = 1'b1;
                io_mem_rsp_data  = d;
            end
            tick();
            io_mem_rsp_valid = 1'b0;
        end
        check("busy_done", 64'(io_busy), 64'd0);
        check("ready_done", 64'(io_in_ready), 64'd1);
    endtask

    initial begin
        reset            = 1'b0;
        io_in_valid      = 1'b0;
        io_in_sel        = '0;
        io_in_src        = {32'hA5A5_0003, 32'h1234_5678, 32'hFFFF_0001, 32'h0BAD_0000};
        io_in_rd         = '0;
        io_in_regwrite   = 1'b0;
        io_in_funct3     = '0;
        io_in_addr_lo    = '0;
        io_mem_rsp_valid = 1'b0;
        io_mem_rsp_data  = '0;

        tick();
        tick();
        check("rst_wen", 64'(io_rf_wen), 64'd0);
        check("rst_ready", 64'(io_in_ready), 64'd0);
        check("rst_busy", 64'(io_busy), 64'd0);
        check("rst_waddr", 64'(io_rf_waddr), 64'd0);
        check("rst_wdata", 64'(io_rf_wdata), 64'd0);
        check("rst_timeout", 64'(io_err_timeout), 64'd0);
        check("rst_unexp", 64'(io_err_unexp_rsp), 64'd0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", 64'(io_in_ready), 64'd1);

        // ALU-style source, single-cycle latency
        exp_q.push_back({5'd5, 32'h1234_5678});
        issue(2'd2, 5'd5, 1'b1, 3'b000, 2'd0);
        check("t1_wen_count", 64'(wen_seen), 64'd1);
        check("t1_ready", 64'(io_in_ready), 64'd1);

        // rd=0 never writes
        issue(2'd0, 5'd0, 1'b1, 3'b000, 2'd0);
        tick();
        tick();
        check("t2_wen_count", 64'(wen_seen), 64'd1);

        do_load(3'b000, 2'd3, 32'h80FF_FF00, 5'd7, 3, 32'hFFFF_FF80);
        do_load(3'b101, 2'd2, 32'hBEEF_1234, 5'd8, 1, 32'h0000_BEEF);
        do_load(3'b001, 2'd2, 32'hBEEF_1234, 5'd9, 2, 32'hFFFF_BEEF);
        do_load(3'b100, 2'd1, 32'h0000_A500, 5'd13, 1, 32'h0000_00A5);
        // response on the last cycle before timeout completes the load
        do_load(3'b010, 2'd0, 32'hCAFE_F00D, 5'd10, TIMEOUT, 32'hCAFE_F00D);
        check("edge_no_timeout", 64'(to_seen), 64'd0);
        check("loads_wen_count", 64'(wen_seen), 64'd6);

        // timeout: no response at all
        issue(2'd1, 5'd11, 1'b1, 3'b010, 2'd0);
        tick();
        tick();
        tick();
        check("to_busy_before", 64'(io_busy), 64'd1);
        tick();
        check("to_busy_after", 64'(io_busy), 64'd0);
        check("to_pulse", 64'(io_err_timeout), 64'd1);
        check("to_ready", 64'(io_in_ready), 64'd1);
        tick();
        check("to_pulse_end", 64'(io_err_timeout), 64'd0);
        check("to_count", 64'(to_seen), 64'd1);
        check("to_no_write", 64'(wen_seen), 64'd6);
        check("unexp_before", 64'(io_err_unexp_rsp), 64'd0);
        io_mem_rsp_valid = 1'b1;
        io_mem_rsp_data  = 32'h5555_5555;
        tick();
        io_mem_rsp_valid = 1'b0;
        check("unexp_set", 64'(io_err_unexp_rsp), 64'd1);
        tick();
        check("unexp_sticky", 64'(io_err_unexp_rsp), 64'd1);
        check("unexp_no_write", 64'(wen_seen), 64'd6);

        // reset while waiting for memory
        issue(2'd1, 5'd12, 1'b1, 3'b010, 2'd0);
        tick();
        check("r6_busy", 64'(io_busy), 64'd1);
        reset = 1'b0;
        tick();
        check("r6_wen", 64'(io_rf_wen), 64'd0);
        check("r6_busy_clr", 64'(io_busy), 64'd0);
        check("r6_ready", 64'(io_in_ready), 64'd0);
        check("r6_unexp_clr", 64'(io_err_unexp_rsp), 64'd0);
        check("r6_waddr", 64'(io_rf_waddr), 64'd0);
        check("r6_wdata", 64'(io_rf_wdata), 64'd0);
        reset = 1'b1;
        tick();
        check("r6_idle_ready", 64'(io_in_ready), 64'd1);
        check("r6_no_timeout", 64'(to_seen), 64'd1);

        exp_q.push_back({5'd31, 32'hA5A5_0003});
        issue(2'd3, 5'd31, 1'b1, 3'b000, 2'd0);
        tick();
        check("final_wen_count", 64'(wen_seen), 64'd7);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
